// File: rtl/multdiv_sequencer.sv
// rtl/multdiv_sequencer.sv - multi-cycle unsigned MULTU/DIVU sequencer owning HI/LO
// Optional MULTDIV_EARLY_TERM_EN: MULT finishes once the remaining multiplier bits are zero.
module multdiv_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  input  logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [3:0] MULTU_AC = 4'd7;
  localparam logic [3:0] DIVU_AC  = 4'd8;
  localparam logic [3:0] MFHI_AC  = 4'd9;
  localparam logic [3:0] MFLO_AC  = 4'd10;

  typedef enum logic [1:0] {S_IDLE, S_MULT, S_DIV, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               dbz_q, dbz_d;

  logic               is_start, is_req, accept, last_iter, mul_fin;
  logic [WIDTH:0]     mul_sum, rem_sh;
  logic               rem_ge;
  logic [2*WIDTH-1:0] mul_next, mul_final, div_next;
`ifdef MULTDIV_EARLY_TERM_EN
  logic [WIDTH-1:0]   mul_left;
  logic [CNT_W-1:0]   mul_rest;
`endif

  always_comb begin
    is_start  = (alu_ctrl == MULTU_AC) || (alu_ctrl == DIVU_AC);
    is_req    = is_start || (alu_ctrl == MFHI_AC) || (alu_ctrl == MFLO_AC);
    busy      = (state_q == S_MULT) || (state_q == S_DIV);
    stall     = busy && op_valid && is_req;
    accept    = op_valid && is_start && ((state_q == S_IDLE) || (state_q == S_DONE));
    last_iter = (cnt_q == CNT_W'(WIDTH - 1));

    // Product register holds {partial product, unconsumed multiplier bits}.
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};
`ifdef MULTDIV_EARLY_TERM_EN
    // Once no multiplier bits remain, the leftover iterations are pure shifts.
    mul_left  = mul_next[WIDTH-1:0] & ({WIDTH{1'b1}} >> (cnt_q + CNT_W'(1)));
    mul_rest  = CNT_W'(WIDTH - 1) - cnt_q;
    mul_fin   = last_iter || (mul_left == '0);
    mul_final = mul_next >> mul_rest;
`else
    mul_fin   = last_iter;
    mul_final = mul_next;
`endif

    // Remainder:quotient pair; the shifted-out remainder MSB is kept for the compare.
    rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    rem_ge   = rem_sh >= {1'b0, opb_q};
    div_next = {(rem_ge ? (rem_sh[WIDTH-1:0] - opb_q) : rem_sh[WIDTH-1:0]),
                acc_q[WIDTH-2:0], rem_ge};

    done        = (state_q == S_DONE);
    div_by_zero = done && dbz_q;
    hi          = hi_q;
    lo          = lo_q;
    result      = (alu_ctrl == MFHI_AC) ? hi_q : lo_q;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opb_d   = opb_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dbz_d   = dbz_q;

    case (state_q)
      S_MULT: begin
        acc_d = mul_next;
        cnt_d = cnt_q + CNT_W'(1);
        if (mul_fin) begin
          state_d = S_DONE;
          hi_d    = mul_final[2*WIDTH-1:WIDTH];
          lo_d    = mul_final[WIDTH-1:0];
          dbz_d   = 1'b0;
        end
      end
      S_DIV: begin
        acc_d = div_next;
        cnt_d = cnt_q + CNT_W'(1);
        if (last_iter) begin
          state_d = S_DONE;
          hi_d    = div_next[2*WIDTH-1:WIDTH];
          lo_d    = div_next[WIDTH-1:0];
          dbz_d   = 1'b0;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        dbz_d   = 1'b0;
      end
      default: ;
    endcase

    // A start in DONE overrides the return to IDLE.
    if (accept) begin
      cnt_d = '0;
      dbz_d = 1'b0;
      if (alu_ctrl == DIVU_AC) begin
        if (b == '0) begin
          state_d = S_DONE;
          hi_d    = a;
          lo_d    = {WIDTH{1'b1}};
          dbz_d   = 1'b1;
        end else begin
          state_d = S_DIV;
          acc_d   = {{WIDTH{1'b0}}, a};
          opb_d   = b;
        end
      end else begin
`ifdef MULTDIV_EARLY_TERM_EN
        if (b == '0) begin
          state_d = S_DONE;
          hi_d    = '0;
          lo_d    = '0;
        end else begin
          state_d = S_MULT;
          acc_d   = {{WIDTH{1'b0}}, b};
          opb_d   = a;
        end
`else
        state_d = S_MULT;
        acc_d   = {{WIDTH{1'b0}}, b};
        opb_d   = a;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opb_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opb_q   <= opb_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dbz_q   <= dbz_d;
    end
  end

endmodule

// File: tb/tb_multdiv_sequencer.sv
// tb/tb_multdiv_sequencer.sv - self-checking bench for multdiv_sequencer
module tb_multdiv_sequencer;
  localparam int W = 32;
  localparam logic [3:0] MULTU = 4'd7, DIVU = 4'd8, MFHI = 4'd9, MFLO = 4'd10;

  logic          clk = 1'b0;
  logic          rst, op_valid;
  logic [3:0]    alu_ctrl;
  logic [W-1:0]  a, b;
  logic          busy, stall, done, div_by_zero;
  logic [W-1:0]  result, hi, lo;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  multdiv_sequencer #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .alu_ctrl(alu_ctrl), .a(a), .b(b),
    .busy(busy), .stall(stall), .done(done), .div_by_zero(div_by_zero),
    .result(result), .hi(hi), .lo(lo)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Expected accept-to-done latency in cycles.
  function automatic int exp_lat(input logic is_div, input logic [W-1:0] mb);
    if (is_div) return (mb == 0) ? 1 : W + 1;
`ifdef MULTDIV_EARLY_TERM_EN
    if (mb == 0) return 1;
    for (int i = W - 1; i >= 0; i--) if (mb[i]) return i + 2;
    return 1;
`else
    return W + 1;
`endif
  endfunction

  task automatic issue(input logic [3:0] op, input logic [W-1:0] ia, input logic [W-1:0] ib);
    @(negedge clk);
    op_valid = 1'b1; alu_ctrl = op; a = ia; b = ib;
    @(posedge clk);
    #1;
    op_valid = 1'b0; alu_ctrl = 4'd0; a = $urandom; b = $urandom;
  endtask

  task automatic wait_done(output int lat, output int busy_cyc,
                           output logic [W-1:0] h, output logic [W-1:0] l, output logic dz);
    lat = -1; busy_cyc = 0; h = '0; l = '0; dz = 1'b0;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (busy) busy_cyc++;
      if (done) begin
        lat = n; h = hi; l = lo; dz = div_by_zero;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; op_valid = 1'b0; alu_ctrl = 4'd0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({busy, stall, done, div_by_zero} !== 4'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b want 0000", {busy, stall, done, div_by_zero});
    end
    n_tests++;
    if ({hi, lo} !== 64'h0) begin
      n_fail++; $display("FAIL reset_hilo: got %h want 0", {hi, lo});
    end
    rst = 1'b0;
  endtask

  task automatic test_mult;
    logic [W-1:0] ta[12], tb_[12];
    logic [2*W-1:0] p;
    logic [W-1:0] h, l;
    logic dz;
    int lat, bc, el;
    ta[0] = 32'hFFFFFFFF; tb_[0] = 32'hFFFFFFFF;
    ta[1] = 32'd3;        tb_[1] = 32'd5;
    ta[2] = 32'd6;        tb_[2] = 32'd7;
    ta[3] = 32'h0;        tb_[3] = 32'hDEADBEEF;
    ta[4] = 32'hCAFEF00D; tb_[4] = 32'h0;
    ta[5] = 32'h80000000; tb_[5] = 32'h80000000;
    for (int i = 6; i < 12; i++) begin
      ta[i] = $urandom; tb_[i] = $urandom >> $urandom_range(0, 31);
    end
    for (int i = 0; i < 12; i++) begin
      p  = 64'(ta[i]) * 64'(tb_[i]);
      el = exp_lat(1'b0, tb_[i]);
      issue(MULTU, ta[i], tb_[i]);
      wait_done(lat, bc, h, l, dz);
      n_tests++;
      if (lat != el) begin n_fail++; $display("FAIL mult_latency[%0d]: got %0d want %0d", i, lat, el); end
      n_tests++;
      if ({h, l} !== p) begin n_fail++; $display("FAIL mult_product[%0d]: got %h want %h", i, {h, l}, p); end
      n_tests++;
      if (dz !== 1'b0) begin n_fail++; $display("FAIL mult_dbz[%0d]: got %b want 0", i, dz); end
      n_tests++;
      if (bc != el - 1) begin n_fail++; $display("FAIL mult_busy[%0d]: got %0d want %0d", i, bc, el - 1); end
    end
  endtask

  task automatic test_div;
    logic [W-1:0] ta[10], tb_[10];
    logic [W-1:0] h, l;
    logic dz;
    int lat, bc;
    ta[0] = 32'd100;      tb_[0] = 32'd7;
    ta[1] = 32'h80000000; tb_[1] = 32'd1;
    ta[2] = 32'hFFFFFFFF; tb_[2] = 32'hFFFFFFFF;
    ta[3] = 32'd5;        tb_[3] = 32'hFFFFFFFE;
    for (int i = 4; i < 10; i++) begin
      ta[i] = $urandom;
      tb_[i] = ($urandom >> $urandom_range(0, 31)) | 32'd1;
    end
    for (int i = 0; i < 10; i++) begin
      issue(DIVU, ta[i], tb_[i]);
      wait_done(lat, bc, h, l, dz);
      n_tests++;
      if (lat != W + 1) begin n_fail++; $display("FAIL div_latency[%0d]: got %0d want %0d", i, lat, W + 1); end
      n_tests++;
      if (l !== ta[i] / tb_[i]) begin n_fail++; $display("FAIL div_quot[%0d]: got %h want %h", i, l, ta[i] / tb_[i]); end
      n_tests++;
      if (h !== ta[i] % tb_[i]) begin n_fail++; $display("FAIL div_rem[%0d]: got %h want %h", i, h, ta[i] % tb_[i]); end
      n_tests++;
      if (dz !== 1'b0) begin n_fail++; $display("FAIL div_dbz[%0d]: got %b want 0", i, dz); end
      alu_ctrl = MFHI; #1;
      n_tests++;
      if (result !== ta[i] % tb_[i]) begin n_fail++; $display("FAIL result_hi[%0d]: got %h want %h", i, result, ta[i] % tb_[i]); end
      alu_ctrl = MFLO; #1;
      n_tests++;
      if (result !== ta[i] / tb_[i]) begin n_fail++; $display("FAIL result_lo[%0d]: got %h want %h", i, result, ta[i] / tb_[i]); end
      alu_ctrl = 4'd0;
    end
  endtask

  task automatic test_div_zero;
    logic [W-1:0] ta[2];
    logic [W-1:0] h, l;
    logic dz;
    int lat, bc;
    ta[0] = 32'h12345678; ta[1] = 32'h0;
    for (int i = 0; i < 2; i++) begin
      issue(DIVU, ta[i], 32'h0);
      wait_done(lat, bc, h, l, dz);
      n_tests++;
      if (lat != 1) begin n_fail++; $display("FAIL dz_latency[%0d]: got %0d want 1", i, lat); end
      n_tests++;
      if (dz !== 1'b1) begin n_fail++; $display("FAIL dz_flag[%0d]: got %b want 1", i, dz); end
      n_tests++;
      if ({h, l} !== {ta[i], 32'hFFFFFFFF}) begin
        n_fail++; $display("FAIL dz_hilo[%0d]: got %h want %h", i, {h, l}, {ta[i], 32'hFFFFFFFF});
      end
      n_tests++;
      if (bc != 0) begin n_fail++; $display("FAIL dz_busy[%0d]: got %0d want 0", i, bc); end
    end
  endtask

  task automatic test_stall_mflo;
    int el;
    el = exp_lat(1'b0, 32'd7);
    issue(MULTU, 32'd6, 32'd7);
    @(posedge clk); #1;
    op_valid = 1'b1; alu_ctrl = MFLO;
    for (int n = 2; n <= el; n++) begin
      @(negedge clk);
      n_tests++;
      if (stall !== (n < el)) begin n_fail++; $display("FAIL mflo_stall[c%0d]: got %b want %b", n, stall, n < el); end
      if (n == el) begin
        n_tests++;
        if (done !== 1'b1) begin n_fail++; $display("FAIL mflo_done: got %b want 1", done); end
        n_tests++;
        if (result !== 32'd42) begin n_fail++; $display("FAIL mflo_result: got %h want %h", result, 32'd42); end
      end
    end
    op_valid = 1'b0; alu_ctrl = 4'd0;
  endtask

  task automatic test_back_to_back;
    logic [2*W-1:0] p1;
    logic [W-1:0] h, l;
    logic dz;
    int lat, bc, el1, el2;
    p1  = 64'(32'd123) * 64'(32'h80000001);
    el1 = exp_lat(1'b0, 32'h80000001);
    el2 = exp_lat(1'b0, 32'd11);
    issue(MULTU, 32'd123, 32'h80000001);
    @(posedge clk); #1;
    op_valid = 1'b1; alu_ctrl = MULTU; a = 32'd9; b = 32'd11;
    for (int n = 2; n <= el1; n++) begin
      @(negedge clk);
      n_tests++;
      if (stall !== (n < el1)) begin n_fail++; $display("FAIL b2b_stall[c%0d]: got %b want %b", n, stall, n < el1); end
      if (n == el1) begin
        n_tests++;
        if (done !== 1'b1 || {hi, lo} !== p1) begin
          n_fail++; $display("FAIL b2b_first: got done=%b %h want done=1 %h", done, {hi, lo}, p1);
        end
      end
    end
    @(posedge clk); #1;
    op_valid = 1'b0; alu_ctrl = 4'd0; a = $urandom; b = $urandom;
    wait_done(lat, bc, h, l, dz);
    n_tests++;
    if (lat != el2) begin n_fail++; $display("FAIL b2b_latency: got %0d want %0d", lat, el2); end
    n_tests++;
    if ({h, l} !== 64'd99) begin n_fail++; $display("FAIL b2b_second: got %h want %h", {h, l}, 64'd99); end
  endtask

  task automatic test_reset_mid;
    logic [W-1:0] h, l;
    logic dz;
    int lat, bc, seen;
    issue(MULTU, 32'h1234, 32'h5678);
    wait_done(lat, bc, h, l, dz);
    issue(MULTU, $urandom | 32'h1, 32'h80000000 | $urandom);
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL rmid_flags: got busy=%b done=%b want 0 0", busy, done); end
    n_tests++;
    if ({hi, lo} !== 64'h0) begin n_fail++; $display("FAIL rmid_hilo: got %h want 0", {hi, lo}); end
    rst = 1'b0;
    seen = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    n_tests++;
    if (seen != 0) begin n_fail++; $display("FAIL rmid_nodone: got %0d active cycles want 0", seen); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_stall_mflo();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
